// File: rtl/filtro_pkg.sv
// Shared definitions for the interpolation filter stages: FSM states,
// half-band kernel coefficients, rounding constants and width helpers.
package filtro_pkg;

  typedef enum logic [1:0] {
    ST_IN   = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } state_e;

  localparam int C_OUTER = -1;
  localparam int C_INNER = 9;
  localparam int ROUND   = 8;
  localparam int SHIFT   = 4;

  // Port sample width: two guard bits above the base sample width.
  function automatic int sample_w(input int data_w);
    return data_w + 2;
  endfunction

  // Accumulator width wide enough for the 4-tap odd-phase sum.
  function automatic int acc_w(input int data_w);
    return data_w + 8;
  endfunction

endpackage

// File: rtl/interp_up2_kernel.sv
// Odd-phase half-band midpoint: (-h3 + 9*h2 + 9*h1 - h0 + 8) >>> 4,
// saturated back to the sample range. Purely combinational.
module interp_up2_kernel
  import filtro_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_w(DATA_WIDTH)
) (
  input  logic signed [DATA_WIDTH+1:0] h0_i,
  input  logic signed [DATA_WIDTH+1:0] h1_i,
  input  logic signed [DATA_WIDTH+1:0] h2_i,
  input  logic signed [DATA_WIDTH+1:0] h3_i,
  output logic signed [DATA_WIDTH+1:0] odd_o
);

  localparam int SW = sample_w(DATA_WIDTH);

  localparam logic signed [ACC_WIDTH-1:0] K_OUT  = ACC_WIDTH'(C_OUTER);
  localparam logic signed [ACC_WIDTH-1:0] K_IN   = ACC_WIDTH'(C_INNER);
  localparam logic signed [ACC_WIDTH-1:0] K_RND  = ACC_WIDTH'(ROUND);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((1 <<< (SW - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(1 <<< (SW - 1)));

  // Add half an LSB of the output scale, then floor-shift.
  function automatic logic signed [ACC_WIDTH-1:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] v
  );
    return (v + K_RND) >>> SHIFT;
  endfunction

  // Clip to the representable sample range.
  function automatic logic signed [SW-1:0] sat_sample(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (v > SAT_HI) return SAT_HI[SW-1:0];
    if (v < SAT_LO) return SAT_LO[SW-1:0];
    return v[SW-1:0];
  endfunction

  logic signed [ACC_WIDTH-1:0] x0, x1, x2, x3;
  logic signed [ACC_WIDTH-1:0] acc;

  assign x0 = ACC_WIDTH'(h0_i);
  assign x1 = ACC_WIDTH'(h1_i);
  assign x2 = ACC_WIDTH'(h2_i);
  assign x3 = ACC_WIDTH'(h3_i);

  // Symmetric 4-tap sum; the accumulator width leaves headroom, so no overflow.
  always_comb begin
    acc   = K_OUT * x3 + K_IN * x2 + K_IN * x1 + K_OUT * x0;
    odd_o = sat_sample(round_shift(acc));
  end

endmodule

// File: rtl/interp_up2_stream.sv
// Streaming x2 interpolator: each accepted input (after a 3-sample warm-up)
// produces an even output (delayed input) followed by an odd output
// (half-band midpoint). Valid/ready on both sides; enable freezes everything.
module interp_up2_stream
  import filtro_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_w(DATA_WIDTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH+1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH+1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int SW = sample_w(DATA_WIDTH);

  state_e               state_q, state_d;
  logic signed [SW-1:0] h0_q, h1_q, h2_q, h3_q;
  logic signed [SW-1:0] h0_d, h1_d, h2_d, h3_d;
  logic [1:0]           fill_q, fill_d;
  logic signed [SW-1:0] out_data_q, out_data_d;
  logic signed [SW-1:0] odd_sample;
  logic                 accept, xfer;

  // Handshakes are gated by enable and reset so a frozen or resetting block
  // neither takes input nor presents output.
  assign in_ready  = enable & ~reset & (state_q == ST_IN);
  assign out_valid = enable & ~reset & (state_q != ST_IN);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign out_data  = out_data_q;

  // Odd sample is computed from the current (already shifted) history,
  // which is exactly what is held while in ST_EVEN.
  interp_up2_kernel #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_kernel (
    .h0_i (h0_q),
    .h1_i (h1_q),
    .h2_i (h2_q),
    .h3_i (h3_q),
    .odd_o(odd_sample)
  );

  // Next-state logic: shift history on accept, then emit even and odd outputs.
  always_comb begin
    state_d    = state_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    h3_d       = h3_q;
    fill_d     = fill_q;
    out_data_d = out_data_q;
    unique case (state_q)
      ST_IN: begin
        if (accept) begin
          h3_d = h2_q;
          h2_d = h1_q;
          h1_d = h0_q;
          h0_d = in_data;
          if (fill_q != 2'd3) begin
            fill_d = fill_q + 2'd1;
          end else begin
            // Pre-shift h1 becomes h2 after the shift: the x[m-2] sample.
            state_d    = ST_EVEN;
            out_data_d = h1_q;
          end
        end
      end
      ST_EVEN: begin
        if (xfer) begin
          state_d    = ST_ODD;
          out_data_d = odd_sample;
        end
      end
      ST_ODD: begin
        if (xfer) state_d = ST_IN;
      end
      default: state_d = ST_IN;
    endcase
  end

  // State register; reset clears history, fill count and any pending output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IN;
      h0_q       <= '0;
      h1_q       <= '0;
      h2_q       <= '0;
      h3_q       <= '0;
      fill_q     <= 2'd0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
      h3_q       <= h3_d;
      fill_q     <= fill_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_interp_up2_stream.sv
// Self-checking bench for interp_up2_stream: directed scenarios plus a
// randomized run, all checked against a sample-history reference model.
module tb_interp_up2_stream;

  localparam int DW = 8;
  localparam int SW = DW + 2;
  localparam int SMAX = (1 << (SW - 1)) - 1;
  localparam int SMIN = -(1 << (SW - 1));

  logic clock = 1'b0;
  logic reset, enable, in_valid, in_ready, out_valid, out_ready;
  logic signed [SW-1:0] in_data, out_data;

  int n_vec = 0;
  int n_err = 0;

  int hist[$];
  int exp_q[$];
  logic acc_seen;
  logic xfer_seen;
  logic signed [31:0] xfer_val;

  interp_up2_stream #(.DATA_WIDTH(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // Midpoint from four consecutive samples a (oldest) .. d (newest).
  function automatic int ref_odd(int a, int b, int c, int d);
    int s, y;
    s = -a + 9 * b + 9 * c - d + 8;
    if (s >= 0) y = s / 16;
    else        y = -((-s + 15) / 16);
    if (y > SMAX) y = SMAX;
    if (y < SMIN) y = SMIN;
    return y;
  endfunction

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_bit(string tag, logic got, logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: check handshake/data at the negedge, advance the model, step.
  task automatic cycle();
    int n;
    @(negedge clock);
    acc_seen  = 1'b0;
    xfer_seen = 1'b0;
    chk_bit("in_ready",  in_ready,  enable && !reset && exp_q.size() == 0);
    chk_bit("out_valid", out_valid, enable && !reset && exp_q.size() != 0);
    if (!reset && enable) begin
      if (exp_q.size() != 0) begin
        chk("out_data", 32'(out_data), exp_q[0]);
        if (out_ready) begin
          xfer_seen = 1'b1;
          xfer_val  = 32'(out_data);
          void'(exp_q.pop_front());
        end
      end else if (in_valid) begin
        acc_seen = 1'b1;
        hist.push_back(int'(in_data));
        n = hist.size();
        if (n >= 4) begin
          exp_q.push_back(hist[n-3]);
          exp_q.push_back(ref_odd(hist[n-4], hist[n-3], hist[n-2], hist[n-1]));
        end
      end
    end
    @(posedge clock);
    #1;
    if (reset) begin
      hist.delete();
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    cycle();
    reset = 1'b0;
    chk("rst_out_data", 32'(out_data), 0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
  endtask

  task automatic feed(int v);
    in_data  = SW'(v);
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (acc_seen) break;
    end
    chk_bit("feed_accept", acc_seen, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic expect_xfer(string tag, int v);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (xfer_seen) break;
    end
    chk_bit({tag, "_seen"}, xfer_seen, 1'b1);
    if (xfer_seen) chk(tag, xfer_val, v);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n_acc;
    int sel;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // 1. warm-up
    do_reset();
    out_ready = 1'b1;
    feed(16); feed(32); feed(48); feed(64);
    expect_xfer("t1_even", 32);
    expect_xfer("t1_odd", 40);

    // 2. continuation and throughput
    feed(80);
    expect_xfer("t2_even", 48);
    expect_xfer("t2_odd", 56);
    in_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      in_data = SW'($urandom);
      cycle();
      if (acc_seen) n_acc++;
    end
    in_valid = 1'b0;
    chk("t2_tput", n_acc, 3);
    drain();

    // 3. saturation both ways
    do_reset();
    feed(0); feed(511); feed(511); feed(0);
    expect_xfer("t3_pos_even", 511);
    expect_xfer("t3_pos_odd", 511);
    do_reset();
    feed(0); feed(-512); feed(-512); feed(0);
    expect_xfer("t3_neg_even", -512);
    expect_xfer("t3_neg_odd", -512);

    // 4. backpressure in ST_EVEN
    do_reset();
    out_ready = 1'b0;
    feed(16); feed(32); feed(48); feed(64);
    cycle(); cycle(); cycle();
    chk("t4_hold", 32'(out_data), 32);
    chk_bit("t4_valid", out_valid, 1'b1);
    chk_bit("t4_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    expect_xfer("t4_even", 32);
    expect_xfer("t4_odd", 40);

    // 5. enable dropped in ST_ODD
    do_reset();
    feed(16); feed(32); feed(48); feed(64);
    expect_xfer("t5_even", 32);
    enable = 1'b0;
    cycle(); cycle();
    chk("t5_frozen", 32'(out_data), 40);
    enable = 1'b1;
    expect_xfer("t5_odd", 40);
    cycle();

    // 6. reset while in ST_EVEN
    do_reset();
    out_ready = 1'b0;
    feed(100); feed(-50); feed(7); feed(300);
    cycle();
    do_reset();
    out_ready = 1'b1;
    feed(16); feed(32); feed(48); feed(64);
    expect_xfer("t6_even", 32);
    expect_xfer("t6_odd", 40);

    // randomized traffic with frequent extreme samples
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      if (sel == 0)      in_data = SW'(SMAX);
      else if (sel == 1) in_data = SW'(SMIN);
      else               in_data = SW'($urandom);
      cycle();
    end
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
